// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the multiplexed seven-segment driver.
// Segment patterns are active-low and ordered {G,F,E,D,C,B,A}.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry n holds the pattern for hex digit n. Digit F is the first element, digit 0 the last.
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_e;

    function automatic logic [6:0] hex_pattern(input logic [3:0] nibble);
        return HEX_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle between the character logic (master) and the scan driver (slave).
// The driver's outputs go to the board's shared segment and anode pins.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;

    modport master (
        output load, digits_in, dp_in, digit_en, blink_mask,
        input  seg, dp, an
    );

    modport slave (
        input  load, digits_in, dp_in, digit_en, blink_mask,
        output seg, dp, an
    );
endinterface

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_pattern(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with per-digit dp, blanking, blink and dead time.
//   phase | meaning
//   BLANK | prescaler < BLANK_CYCLES, all anodes off (anti-ghosting)
//   DRIVE | anode of the current digit on, segments from shadow state
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_LOG2   = 25
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave io_bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [BLINK_LOG2-1:0]   r_blink;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_dp_req;
    logic [NUM_DIGITS-1:0]   r_en;
    logic [NUM_DIGITS-1:0]   r_blink_mask;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    phase_e                  w_phase;
    logic                    w_presc_wrap;
    logic [3:0]              w_nibble;
    logic [6:0]              w_pattern;
    logic                    w_sel_en;
    logic                    w_sel_dp;
    logic                    w_sel_blink;
    logic                    w_dark;
    logic [NUM_DIGITS-1:0]   w_an_drive;

    assign w_phase      = (r_presc < PW'(BLANK_CYCLES)) ? BLANK : DRIVE;
    assign w_presc_wrap = (r_presc == PW'(SCAN_DIV - 1));

    // Select everything belonging to the current digit in one place.
    always_comb begin
        w_nibble    = 4'h0;
        w_sel_en    = 1'b0;
        w_sel_dp    = 1'b0;
        w_sel_blink = 1'b0;
        w_an_drive  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nibble      = r_digits[4*i +: 4];
                w_sel_en      = r_en[i];
                w_sel_dp      = r_dp_req[i];
                w_sel_blink   = r_blink_mask[i];
                w_an_drive[i] = 1'b0;
            end
        end
    end

    assign w_dark = !w_sel_en || (w_sel_blink && r_blink[BLINK_LOG2-1]);

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_blink      <= '0;
            r_digits     <= '0;
            r_dp_req     <= '0;
            r_en         <= '0;
            r_blink_mask <= '0;
        end else begin
            r_blink <= r_blink + BLINK_LOG2'(1);
            if (w_presc_wrap) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            if (io_bus.load) begin
                r_digits     <= io_bus.digits_in;
                r_dp_req     <= io_bus.dp_in;
                r_en         <= io_bus.digit_en;
                r_blink_mask <= io_bus.blink_mask;
            end
        end
    end

    // A dark digit still drives its anode so the scan duty cycle stays constant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
            r_an  <= '1;
        end else begin
            case (w_phase)
                DRIVE: begin
                    r_an <= w_an_drive;
                    if (w_dark) begin
                        r_seg <= SEG_OFF;
                        r_dp  <= 1'b1;
                    end else begin
                        r_seg <= w_pattern;
                        r_dp  <= ~w_sel_dp;
                    end
                end
                default: begin
                    r_seg <= SEG_OFF;
                    r_dp  <= 1'b1;
                    r_an  <= '1;
                end
            endcase
        end
    end

    assign io_bus.seg = r_seg;
    assign io_bus.dp  = r_dp;
    assign io_bus.an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a 4-digit instance driven from a vector table
// and a 1-digit instance exercised after a mid-slot reset.
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   ecount   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus4 ();
    seg7_scan_driver_if #(.NUM_DIGITS(1)) bus1 ();

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .BLINK_LOG2(6)
    ) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus4)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(1), .SCAN_DIV(8), .BLANK_CYCLES(2), .BLINK_LOG2(6)
    ) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus1)
    );

    typedef struct {
        int          ecyc;
        logic        ld;
        logic [15:0] dig;
        logic [3:0]  dpi;
        logic [3:0]  en;
        logic [3:0]  bm;
        logic [3:0]  x_an;
        logic [6:0]  x_seg;
        logic        x_dp;
    } vec_t;

    vec_t vq[$];

    task automatic tick();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", nm, act, exp, ecount);
        end
    endtask

    initial begin
        int presc;
        int idx;
        logic [3:0] one;
        logic [3:0] x_an4;

        bus4.load = 1'b0; bus4.digits_in = '0; bus4.dp_in = '0; bus4.digit_en = '0; bus4.blink_mask = '0;
        bus1.load = 1'b0; bus1.digits_in = '0; bus1.dp_in = '0; bus1.digit_en = '0; bus1.blink_mask = '0;

        // Edge numbers count clocks after reset release; edge e shows the state of
        // prescaler (e-1)%8, digit ((e-1)/8)%4 and blink counter (e-1)%64.
        vq.push_back('{1,   1'b1, 16'h3A7F, 4'h0, 4'hF, 4'h0, 4'hF, 7'h7F, 1'b1});
        vq.push_back('{2,   1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hF, 7'h7F, 1'b1});
        vq.push_back('{3,   1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hE, 7'h0E, 1'b1});
        vq.push_back('{8,   1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hE, 7'h0E, 1'b1});
        vq.push_back('{9,   1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hF, 7'h7F, 1'b1});
        vq.push_back('{11,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hD, 7'h78, 1'b1});
        vq.push_back('{16,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hD, 7'h78, 1'b1});
        vq.push_back('{19,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hB, 7'h08, 1'b1});
        vq.push_back('{24,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hB, 7'h08, 1'b1});
        vq.push_back('{27,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'h7, 7'h30, 1'b1});
        vq.push_back('{32,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'h7, 7'h30, 1'b1});
        vq.push_back('{33,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hF, 7'h7F, 1'b1});
        vq.push_back('{35,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hE, 7'h0E, 1'b1});
        // blanking of digit 2 and decimal point on digit 0
        vq.push_back('{38,  1'b1, 16'h3A7F, 4'h1, 4'hB, 4'h0, 4'hE, 7'h0E, 1'b1});
        vq.push_back('{39,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hE, 7'h0E, 1'b0});
        vq.push_back('{43,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hD, 7'h78, 1'b1});
        vq.push_back('{51,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hB, 7'h7F, 1'b1});
        vq.push_back('{59,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'h7, 7'h30, 1'b1});
        // blink on digit 0
        vq.push_back('{64,  1'b1, 16'h3A7F, 4'h0, 4'hF, 4'h1, 4'h7, 7'h30, 1'b1});
        vq.push_back('{67,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hE, 7'h0E, 1'b1});
        vq.push_back('{75,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hD, 7'h78, 1'b1});
        vq.push_back('{83,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hB, 7'h08, 1'b1});
        vq.push_back('{99,  1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hE, 7'h7F, 1'b1});
        vq.push_back('{104, 1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hE, 7'h7F, 1'b1});
        vq.push_back('{107, 1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hD, 7'h78, 1'b1});
        vq.push_back('{131, 1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hE, 7'h0E, 1'b1});
        // mid-slot load: digit 0 becomes 8 one edge later
        vq.push_back('{133, 1'b1, 16'h3A78, 4'h0, 4'hF, 4'h1, 4'hE, 7'h0E, 1'b1});
        vq.push_back('{134, 1'b0, 16'h0,    4'h0, 4'h0, 4'h0, 4'hE, 7'h00, 1'b1});

        // power-on reset
        #2 rst = 1'b1;
        #2;
        check("por_seg", 32'(bus4.seg), 32'h7F);
        check("por_dp",  32'(bus4.dp),  32'h1);
        check("por_an",  32'(bus4.an),  32'hF);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        ecount = 0;

        foreach (vq[k]) begin
            while (ecount < vq[k].ecyc - 1) tick();
            if (vq[k].ld) begin
                bus4.digits_in  = vq[k].dig;
                bus4.dp_in      = vq[k].dpi;
                bus4.digit_en   = vq[k].en;
                bus4.blink_mask = vq[k].bm;
                bus4.load       = 1'b1;
            end
            tick();
            bus4.load = 1'b0;
            check($sformatf("vec%0d_an", k),  32'(bus4.an),  32'(vq[k].x_an));
            check($sformatf("vec%0d_seg", k), 32'(bus4.seg), 32'(vq[k].x_seg));
            check($sformatf("vec%0d_dp", k),  32'(bus4.dp),  32'(vq[k].x_dp));
        end

        // reset in the middle of digit 1's DRIVE phase
        while (ecount < 139) tick();
        check("pre_rst_an",  32'(bus4.an),  32'hD);
        check("pre_rst_seg", 32'(bus4.seg), 32'h78);
        #2 rst = 1'b1;
        #1;
        check("async_rst_seg", 32'(bus4.seg), 32'h7F);
        check("async_rst_dp",  32'(bus4.dp),  32'h1);
        check("async_rst_an",  32'(bus4.an),  32'hF);
        check("async_rst_an1", 32'(bus1.an),  32'h1);
        @(posedge clk);
        #1;
        check("held_rst_an", 32'(bus4.an), 32'hF);
        rst = 1'b0;
        ecount = 0;

        // after reset: shadow cleared, so digit 0 drives its anode but stays dark
        bus1.digits_in = 4'h5;
        bus1.digit_en  = 1'b1;
        bus1.load      = 1'b1;
        one = 4'b0001;
        for (int e = 1; e <= 17; e++) begin
            tick();
            bus1.load = 1'b0;
            presc = (ecount - 1) % 8;
            idx   = ((ecount - 1) / 8) % 4;
            x_an4 = (presc < 2) ? 4'hF : ~(one << idx);
            check($sformatf("post_rst_an_e%0d", ecount),  32'(bus4.an),  32'(x_an4));
            check($sformatf("post_rst_seg_e%0d", ecount), 32'(bus4.seg), 32'h7F);
            check($sformatf("single_an_e%0d", ecount),    32'(bus1.an),  (presc < 2) ? 32'h1 : 32'h0);
            check($sformatf("single_seg_e%0d", ecount),   32'(bus1.seg), (presc < 2) ? 32'h7F : 32'h12);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed seven-segment driver for the Morse reader's display. It generalises the single-digit decoder to NUM_DIGITS digits and full hex (0-F) decoding. It adds a per-digit decimal point, blanking, blink, and an anti-ghosting dead time. It sits between the decoded-character logic and the board's shared segment/anode pins.

Parameters:
NUM_DIGITS, 4, digits driven (1..8)
SCAN_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+2)
BLANK_CYCLES, 16, dead cycles at start of each slot with all anodes off (>= 1)
BLINK_LOG2, 25, width of free-running blink counter; its MSB is the blink phase

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
load  in  1  single-cycle strobe; captures digits_in/dp_in/digit_en/blink_mask
digits_in  in  4*NUM_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i]
dp_in  in  NUM_DIGITS  decimal point request per digit (1 = lit)
digit_en  in  NUM_DIGITS  1 = digit shown, 0 = blanked
blink_mask  in  NUM_DIGITS  1 = digit blanked while blink phase = 1
seg  out  7  segments, active-low, seg[0]=A ... seg[6]=G
dp  out  1  decimal point, active-low
an  out  NUM_DIGITS  anodes, active-low, one-hot-low when driving

Behaviour:
- Reset is asynchronous and active-high, on the single clock clk. Reset values: seg=7'h7F, dp=1, an=all 1, shadow registers=0, digit_en shadow=0, prescaler=0, digit index=0, blink counter=0.
- Shadow registers: on a rising edge with load=1, all four inputs are captured. Without load, inputs are ignored and the shadow holds.
- Prescaler counts 0..SCAN_DIV-1 and wraps to 0. On wrap, the digit index advances by 1. The index wraps from NUM_DIGITS-1 to 0.
- Slot phases:
  - BLANK: prescaler < BLANK_CYCLES. an=all 1, seg=7'h7F, dp=1.
  - DRIVE: otherwise. an[idx]=0, other anodes 1.
- In DRIVE, the digit is dark if digit_en[idx]=0, or if blink_mask[idx]=1 and blink phase=1. A dark digit gives seg=7'h7F and dp=1, with the anode still driven.
- Otherwise seg = hex pattern of the shadow nibble and dp = ~dp_in[idx].
- Hex patterns (active-low, {G..A}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- Outputs are registered. They reflect the prescaler/index/shadow state of the previous cycle.
- Load latency: a load at edge k is visible on seg at edge k+1 if the slot is in DRIVE.
- Load during DRIVE takes effect mid-slot; no glitch suppression is required beyond this.
- Blink counter free-runs and wraps at 2^BLINK_LOG2. It is unaffected by load.
- Reset mid-slot: all outputs go to reset values immediately (asynchronously). Scanning restarts at digit 0 in BLANK.
- NUM_DIGITS=1: index stays 0 and an[0] toggles only between BLANK and DRIVE.

Decomposition:
- Package seg7_pkg holds:
  - the SEG_OFF constant (7'h7F),
  - the 16-entry hex pattern table,
  - the phase enum {BLANK, DRIVE}.
- Sub-module seg7_hex_decode: combinational, 4-bit nibble in, 7-bit active-low pattern out, from the package table. It is instantiated once, on the muxed nibble.

Test Plan:
(NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, BLINK_LOG2=6 unless noted)
1. Reset check: assert rst mid-scan → seg=7F, dp=1, an=F immediately; after release, first DRIVE drives an=E at cycles 3..8.
2. Full scan: load digits_in=16'h3A7F, digit_en=F, dp_in=0 → per slot, in this order:
   - an=E with seg=0E,
   - an=D with seg=78,
   - an=B with seg=08,
   - an=7 with seg=30.
   Each slot shows 2 blank cycles; the sequence wraps back to an=E.
3. Blanking and decimal point: digit_en=4'b1011, dp_in=4'b0001 → slot 2 drives an=B with seg=7F and dp=1; slot 0 shows dp=0.
4. Blink: blink_mask=4'b0001 → digit 0 seg=7F while counter MSB=1 (counts 32..63), normal pattern otherwise; digits 1-3 unaffected.
5. Mid-slot load: load digits_in nibble0=8 during slot-0 DRIVE → seg changes from old pattern to 00 one edge after load; an unchanged.
6. Single digit: NUM_DIGITS=1 → an alternates 1 (2 cycles) / 0 (6 cycles); index never leaves 0.
